// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding and keyboard command/response bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronizes one async PS/2 line and flags its falling edges.
// Ports: clk, rst_n (async, active low), din (pad level), sync (synchronized level),
//        fall (1 while sync is low and was high the previous cycle). STAGES >= 2.
module ps2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic              prev;

    // Flops reset to 1: an idle open-drain line floats high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '1;
            prev <= 1'b1;
        end else begin
            sr   <= {sr[STAGES-2:0], din};
            prev <= sr[STAGES-1];
        end
    end

    assign sync = sr[STAGES-1];
    assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter sending one command byte with odd parity.
// Ports: clk, rst_n (async, active low); tx_data/tx_valid/tx_ready byte handshake;
//        ps2_clk_in/ps2_data_in async pad levels; ps2_clk_oe/ps2_data_oe pull-low enables;
//        busy = ~tx_ready; done = one-cycle acked pulse; err = one-cycle nack/timeout pulse.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CMAX = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic [3:0]    bitcnt;
    logic [8:0]    sh;
    logic          bit_oe;
    logic          sync_clk, sync_data, fall_clk, unused_data_fall;
    logic          inhibit_end, timeout, done_d, err_d;

    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ps2_clk_in),
        .sync (sync_clk),
        .fall (fall_clk)
    );

    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_data_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ps2_data_in),
        .sync (sync_data),
        .fall (unused_data_fall)
    );

    // One counter serves both phases: inhibit length, then time since clock release.
    assign inhibit_end = cnt == CW'(INHIBIT_CYCLES);
    assign timeout     = cnt == CW'(TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            sh     <= '0;
            bit_oe <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_d;
            done  <= done_d;
            err   <= err_d;
            cnt   <= (state == IDLE || (state == INHIBIT && inhibit_end)) ? '0 : cnt + 1'b1;
            if (state == IDLE && tx_valid)
                sh <= {~^tx_data, tx_data};
            // Start bit is driven from the last inhibit cycle; each fall then moves to the
            // next bit. Ones shift in behind parity so fall 10 presents the released stop bit.
            if (state == INHIBIT) begin
                bitcnt <= '0;
                bit_oe <= 1'b1;
            end else if (fall_clk && (state == SHIFT || state == ACK)) begin
                bitcnt <= bitcnt + 1'b1;
                bit_oe <= ~sh[0];
                sh     <= {1'b1, sh[8:1]};
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:      state_d = tx_valid ? INHIBIT : IDLE;
            INHIBIT:   state_d = inhibit_end ? SHIFT : INHIBIT;
            SHIFT:     state_d = timeout ? IDLE : (fall_clk && bitcnt == 4'd9) ? ACK : SHIFT;
            ACK:       state_d = (timeout || (fall_clk && sync_data)) ? IDLE : fall_clk ? WAIT_IDLE : ACK;
            WAIT_IDLE: state_d = (timeout || (sync_clk && sync_data)) ? IDLE : WAIT_IDLE;
            default:   state_d = IDLE;
        endcase
        done_d = state == WAIT_IDLE && !timeout && sync_clk && sync_data;
        err_d  = state inside {SHIFT, ACK, WAIT_IDLE} && state_d == IDLE && !done_d;
    end

    always_comb begin
        tx_ready    = state == IDLE;
        busy        = !tx_ready;
        ps2_clk_oe  = state == INHIBIT;
        ps2_data_oe = (state == INHIBIT && inhibit_end) || (state == SHIFT && bit_oe);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model that clocks frames and acks or not.
module tb_ps2_host_tx;

    localparam int IC   = 20;
    localparam int TO   = 2000;
    localparam int HALF = 8;

    logic       clk, rst_n;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, busy, done, err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;
    logic       clk_line, data_line;

    assign clk_line  = !(ps2_clk_oe || dev_clk_low);
    assign data_line = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_pass = 0, n_total = 0;
    int   n_done = 0, n_err = 0, n_acc = 0, n_clash = 0, dev_edges = 0;
    logic rdy_done, rdy_err, oe_err;

    always @(negedge clk) begin
        if (done) begin n_done++; rdy_done = tx_ready; end
        if (err) begin n_err++; rdy_err = tx_ready; oe_err = ps2_clk_oe | ps2_data_oe; end
        if (done && err) n_clash++;
    end

    always @(posedge clk) if (tx_valid && tx_ready) n_acc++;

    // Device side: times the inhibit, records the start bit, then produces up to
    // stop_after clock pulses, sampling the data line on every rising edge.
    task automatic device_frame(input bit ack, input int stop_after, output logic [10:0] got,
                                output int n_low, output int n_both, output bit hung);
        got = '0; n_low = 0; n_both = 0; hung = 0;
        for (int k = 0; k < 100 && !ps2_clk_oe; k++) @(negedge clk);
        if (!ps2_clk_oe) hung = 1;
        for (int k = 0; k < IC * 4 && ps2_clk_oe; k++) begin
            if (ps2_data_oe) n_both++; else n_low++;
            @(negedge clk);
        end
        if (ps2_clk_oe) hung = 1;
        got[0] = data_line;
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 11 && i <= stop_after && !hung; i++) begin
            if (i == 11 && ack) dev_data_low = 1;
            repeat (2) @(negedge clk);
            dev_clk_low = 1;
            dev_edges++;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 0;
            if (i <= 10) got[i] = data_line;
            repeat (HALF) @(negedge clk);
            dev_data_low = 0;
        end
    endtask

    task automatic test_reset;
        n_total++; if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err} !== 6'b100000)
            $display("FAIL reset_held got %b want 100000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err});
        else n_pass++;
        @(negedge clk); rst_n = 1; repeat (3) @(negedge clk);
        n_total++; if (tx_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", tx_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00)
            $display("FAIL reset_oe got %b want 00", {ps2_clk_oe, ps2_data_oe});
        else n_pass++;
    endtask

    task automatic test_frame(input logic [7:0] b, input logic par);
        logic [10:0] got, exp;
        int nl, nb, d0, e0;
        bit h;
        d0 = n_done; e0 = n_err; exp = {1'b1, par, b, 1'b0};
        @(negedge clk); tx_data = b; tx_valid = 1;
        @(negedge clk); tx_valid = 0;
        device_frame(1, 11, got, nl, nb, h);
        for (int k = 0; k < 100 && n_done == d0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_total++; if (h !== 1'b0) $display("FAIL frame_%h_hung got %b want 0", b, h); else n_pass++;
        n_total++; if (nl !== IC) $display("FAIL frame_%h_inhibit got %0d want %0d", b, nl, IC); else n_pass++;
        n_total++; if (nb !== 1) $display("FAIL frame_%h_start_overlap got %0d want 1", b, nb); else n_pass++;
        n_total++; if (got !== exp) $display("FAIL frame_%h_bits got %b want %b", b, got, exp); else n_pass++;
        n_total++; if (n_done - d0 !== 1) $display("FAIL frame_%h_done got %0d want 1", b, n_done - d0); else n_pass++;
        n_total++; if (n_err - e0 !== 0) $display("FAIL frame_%h_err got %0d want 0", b, n_err - e0); else n_pass++;
        n_total++; if (rdy_done !== 1'b1) $display("FAIL frame_%h_ready_at_done got %b want 1", b, rdy_done); else n_pass++;
    endtask

    task automatic test_nack;
        logic [10:0] got;
        int nl, nb, d0, e0;
        bit h;
        d0 = n_done; e0 = n_err;
        @(negedge clk); tx_data = 8'hED; tx_valid = 1;
        @(negedge clk); tx_valid = 0;
        device_frame(0, 11, got, nl, nb, h);
        repeat (20) @(negedge clk);
        n_total++; if (got !== 11'b11111011010) $display("FAIL nack_bits got %b want 11111011010", got); else n_pass++;
        n_total++; if (n_err - e0 !== 1) $display("FAIL nack_err got %0d want 1", n_err - e0); else n_pass++;
        n_total++; if (n_done - d0 !== 0) $display("FAIL nack_done got %0d want 0", n_done - d0); else n_pass++;
        n_total++; if (rdy_err !== 1'b1) $display("FAIL nack_ready got %b want 1", rdy_err); else n_pass++;
        n_total++; if (oe_err !== 1'b0) $display("FAIL nack_oe got %b want 0", oe_err); else n_pass++;
        n_total++; if (n_clash !== 0) $display("FAIL done_err_clash got %0d want 0", n_clash); else n_pass++;
    endtask

    task automatic test_timeout;
        logic [10:0] got;
        int nl, nb, cyc, e0, d0;
        bit h;
        e0 = n_err; d0 = n_done;
        @(negedge clk); tx_data = 8'hFF; tx_valid = 1;
        @(negedge clk); tx_valid = 0;
        device_frame(1, 0, got, nl, nb, h);
        cyc = 4;
        for (int k = 0; k < 3 * TO && !err; k++) begin @(negedge clk); cyc++; end
        n_total++; if (err !== 1'b1) $display("FAIL timeout_seen got %b want 1", err); else n_pass++;
        n_total++; if (cyc < TO || cyc > TO + 2)
            $display("FAIL timeout_cycles got %0d want %0d..%0d", cyc, TO, TO + 2);
        else n_pass++;
        n_total++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001)
            $display("FAIL timeout_idle got %b want 001", {ps2_clk_oe, ps2_data_oe, tx_ready});
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (n_err - e0 !== 1 || n_done - d0 !== 0)
            $display("FAIL timeout_pulses got err=%0d done=%0d want err=1 done=0", n_err - e0, n_done - d0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] got;
        int nl, nb, base;
        bit h;
        base = dev_edges;
        @(negedge clk); tx_data = 8'hED; tx_valid = 1;
        @(negedge clk); tx_valid = 0;
        fork
            device_frame(1, 6, got, nl, nb, h);
            begin
                for (int k = 0; k < 2000 && dev_edges < base + 5; k++) @(negedge clk);
                repeat (5) @(negedge clk);
                n_total++; if (ps2_data_oe !== 1'b1) $display("FAIL mid_bit4_drive got %b want 1", ps2_data_oe); else n_pass++;
                #2 rst_n = 0;
                #1;
                n_total++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00)
                    $display("FAIL mid_reset_release got %b want 00", {ps2_clk_oe, ps2_data_oe});
                else n_pass++;
            end
        join
        repeat (3) @(negedge clk); rst_n = 1;
        repeat (2) @(negedge clk);
        n_total++; if (tx_ready !== 1'b1) $display("FAIL mid_reset_ready got %b want 1", tx_ready); else n_pass++;
        test_frame(8'hF4, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [10:0] g1, g2;
        int l1, b1, l2, b2, a0, d0;
        bit h1, h2;
        a0 = n_acc; d0 = n_done;
        @(negedge clk); tx_data = 8'hED; tx_valid = 1;
        fork
            begin
                device_frame(1, 11, g1, l1, b1, h1);
                device_frame(1, 11, g2, l2, b2, h2);
            end
            begin
                for (int k = 0; k < 5000 && n_acc < a0 + 2; k++) @(negedge clk);
                tx_valid = 0;
            end
        join
        for (int k = 0; k < 100 && n_done < d0 + 2; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_total++; if (g1 !== 11'b11111011010) $display("FAIL b2b_frame1 got %b want 11111011010", g1); else n_pass++;
        n_total++; if (g2 !== 11'b11111011010) $display("FAIL b2b_frame2 got %b want 11111011010", g2); else n_pass++;
        n_total++; if (n_acc - a0 !== 2) $display("FAIL b2b_accepts got %0d want 2", n_acc - a0); else n_pass++;
        n_total++; if (n_done - d0 !== 2) $display("FAIL b2b_done got %0d want 2", n_done - d0); else n_pass++;
        n_total++; if ({h1, h2} !== 2'b00) $display("FAIL b2b_hung got %b want 00", {h1, h2}); else n_pass++;
    endtask

    initial begin
        rst_n = 0; tx_valid = 0; tx_data = 8'h00; dev_clk_low = 0; dev_data_low = 0;
        repeat (3) @(negedge clk);
        test_reset;
        test_frame(8'hED, 1'b1);
        test_frame(8'h01, 1'b0);
        test_frame(8'hFF, 1'b1);
        test_nack;
        test_timeout;
        test_reset_mid_frame;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
